// File: rtl/multn_pkg.sv
// Shared types and limits for the add/shift multiplier controller.
package multn_pkg;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADD   = 3'd1,
    S_SUB   = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  typedef struct packed {
    logic add;
    logic sub;
    logic shift_en;
    logic busy;
    logic done;
  } strobes_t;

  // Moore output decode; anything outside the five legal states yields no strobes.
  function automatic strobes_t decode_strobes(state_e s);
    strobes_t st;
    st = '0;
    case (s)
      S_ADD:   begin st.add      = 1'b1; st.busy = 1'b1; end
      S_SUB:   begin st.sub      = 1'b1; st.busy = 1'b1; end
      S_SHIFT: begin st.shift_en = 1'b1; st.busy = 1'b1; end
      S_DONE:  st.done = 1'b1;
      default: st = '0;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/multn_control_if.sv
// Request/strobe bundle between the multiplier datapath (master) and its controller (slave).
interface multn_control_if;

  logic Run;
  logic ClearA_LoadB;
  logic M;
  logic Signed_Mode;
  logic Clr_Ld;
  logic Shift_En;
  logic Add;
  logic Sub;
  logic Busy;
  logic Done;

  modport master (
    output Run, ClearA_LoadB, M, Signed_Mode,
    input  Clr_Ld, Shift_En, Add, Sub, Busy, Done
  );

  modport slave (
    input  Run, ClearA_LoadB, M, Signed_Mode,
    output Clr_Ld, Shift_En, Add, Sub, Busy, Done
  );

endinterface

// File: rtl/multn_bit_counter.sv
// Multiplier bit index k with synchronous clear, increment and terminal flag.
module multn_bit_counter #(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          inc_i,
  output logic [CW-1:0] k_o,
  output logic          last_o
);

  logic [CW-1:0] k_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q <= '0;
    end else if (clr_i) begin
      k_q <= '0;
    end else if (inc_i) begin
      k_q <= k_q + CW'(1);
    end
  end

  assign k_o    = k_q;
  assign last_o = (k_q == CW'(WIDTH - 1));

endmodule

// File: rtl/multn_control.sv
// Sequencer for a WIDTH-step add/shift multiplier; the final partial product is subtracted in signed mode.
module multn_control
  import multn_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic          Clk,
  input  logic          Reset_n,
  multn_control_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
    $error("multn_control: WIDTH=%0d outside %0d..%0d", WIDTH, WIDTH_MIN, WIDTH_MAX);
  end

  state_e        state_q, state_d;
  strobes_t      strobes_q;
  logic          mode_q;
  logic [CW-1:0] k;
  logic          k_last;
  logic          k_penult;
  logic          cnt_clr;
  logic          cnt_inc;

  assign k_penult = (k == CW'(WIDTH - 2));
  assign cnt_clr  = !(state_q inside {S_ADD, S_SUB, S_SHIFT});
  assign cnt_inc  = (state_q == S_SHIFT) && !k_last;

  multn_bit_counter #(.WIDTH(WIDTH)) u_bit_counter (
    .clk    (Clk),
    .rst_n  (Reset_n),
    .clr_i  (cnt_clr),
    .inc_i  (cnt_inc),
    .k_o    (k),
    .last_o (k_last)
  );

  // NOTE: next state gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:  state_d = bus.Run ? (bus.M ? S_ADD : S_SHIFT) : S_IDLE;
      S_ADD,
      S_SUB:   state_d = S_SHIFT;
      S_SHIFT: begin
        if (k_last)      state_d = S_DONE;
        else if (!bus.M) state_d = S_SHIFT;
        else             state_d = (k_penult && mode_q) ? S_SUB : S_ADD;
      end
      S_DONE:  state_d = bus.Run ? S_DONE : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes are registered from the next state so they line up with state_q.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= S_IDLE;
      strobes_q <= '0;
      mode_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      strobes_q <= decode_strobes(state_d);
      if (state_q == S_IDLE && bus.Run) begin
        mode_q <= bus.Signed_Mode;
      end
    end
  end

  assign bus.Add      = strobes_q.add;
  assign bus.Sub      = strobes_q.sub;
  assign bus.Shift_En = strobes_q.shift_en;
  assign bus.Busy     = strobes_q.busy;
  assign bus.Done     = strobes_q.done;
  // Clear/load passes straight through in IDLE but stays quiet while reset is asserted.
  assign bus.Clr_Ld   = Reset_n && (state_q == S_IDLE) && bus.ClearA_LoadB;

endmodule

// File: tb/tb_multn_control.sv
// Self-checking bench for multn_control: directed and random operations against a strobe-sequence model.
module tb_multn_control;

  localparam int W = 8;

  // Observation vector: {Clr_Ld, Add, Sub, Shift_En, Busy, Done}
  localparam logic [5:0] C_IDLE  = 6'b000000;
  localparam logic [5:0] C_ADD   = 6'b010010;
  localparam logic [5:0] C_SUB   = 6'b001010;
  localparam logic [5:0] C_SHIFT = 6'b000110;
  localparam logic [5:0] C_DONE  = 6'b000001;

  logic Clk     = 1'b0;
  logic Reset_n = 1'b0;

  multn_control_if bus ();

  multn_control #(.WIDTH(W)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus.slave)
  );

  always #5 Clk = ~Clk;

  int vectors     = 0;
  int miscompares = 0;

  function automatic logic [5:0] obs();
    return {bus.Clr_Ld, bus.Add, bus.Sub, bus.Shift_En, bus.Busy, bus.Done};
  endfunction

  task automatic check(input string tag, input logic [5:0] observed, input logic [5:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, observed, expected);
    end
  endtask

  // One full operation from IDLE. hold=0 pulses Run for one edge; hold>0 keeps Run high
  // through the operation and for hold cycles of Done, then releases it.
  task automatic run_op(input logic [W-1:0] bits, input logic mode, input int hold);
    logic [5:0] exp_q[$];
    logic       cl;
    int         s;
    for (int i = 0; i < W; i++) begin
      if (bits[i]) exp_q.push_back((i == W - 1 && mode) ? C_SUB : C_ADD);
      exp_q.push_back(C_SHIFT);
    end

    cl               = 1'($urandom);
    bus.ClearA_LoadB = cl;
    bus.Signed_Mode  = mode;
    bus.Run          = 1'b1;
    bus.M            = bits[0];
    #1 check("idle_start", obs(), {cl, 5'b00000});

    s = 0;
    foreach (exp_q[j]) begin
      @(posedge Clk);
      @(negedge Clk);
      check($sformatf("step%0d", j), obs(), exp_q[j]);
      if (hold == 0) bus.Run = 1'b0;
      bus.Signed_Mode  = 1'($urandom);
      bus.ClearA_LoadB = 1'($urandom);
      if (exp_q[j] == C_SHIFT) begin
        s++;
        bus.M = (s < W) ? bits[s] : 1'($urandom);
      end else begin
        bus.M = 1'($urandom);
      end
    end

    @(posedge Clk);
    @(negedge Clk);
    check("done", obs(), C_DONE);
    for (int c = 1; c < hold; c++) begin
      @(posedge Clk);
      @(negedge Clk);
      check("done_hold", obs(), C_DONE);
    end
    bus.Run = 1'b0;

    @(posedge Clk);
    @(negedge Clk);
    cl = bus.ClearA_LoadB;
    check("back_idle", obs(), {cl, 5'b00000});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.Run          = 1'b0;
    bus.ClearA_LoadB = 1'b1;
    bus.M            = 1'b0;
    bus.Signed_Mode  = 1'b0;

    #12 check("in_reset", obs(), C_IDLE);
    @(negedge Clk);
    Reset_n = 1'b1;
    #1 check("post_reset_clr", obs(), 6'b100000);
    @(posedge Clk);
    @(negedge Clk);
    check("idle_no_run", obs(), 6'b100000);
    bus.ClearA_LoadB = 1'b0;
    #1 check("idle_quiet", obs(), C_IDLE);

    run_op(8'h00, 1'b0, 2);           // all-zero multiplier, shifts only
    run_op(8'hFF, 1'b1, 1);           // signed, final partial product subtracted
    run_op(8'hFF, 1'b0, 0);           // unsigned, all adds
    run_op(8'b0000_1101, 1'b1, 0);    // sparse ones, signed with a zero top bit
    run_op(8'hA5, 1'b0, 5);           // Run held for 5 Done cycles
    run_op(8'h80, 1'b1, 0);           // only the sign bit set
    run_op(8'h80, 1'b0, 0);

    // Asynchronous reset in the third SHIFT, then a clean restart
    @(negedge Clk);
    bus.ClearA_LoadB = 1'b0;
    bus.Signed_Mode  = 1'b0;
    bus.M            = 1'b0;
    bus.Run          = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge Clk);
      @(negedge Clk);
      check("pre_reset_shift", obs(), C_SHIFT);
    end
    bus.ClearA_LoadB = 1'b1;
    #2 Reset_n = 1'b0;
    #1 check("async_reset", obs(), C_IDLE);
    bus.Run = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    check("reset_held", obs(), C_IDLE);
    Reset_n = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    check("reset_release_idle", obs(), 6'b100000);
    bus.ClearA_LoadB = 1'b0;
    run_op(8'b0100_1011, 1'b1, 0);

    for (int r = 0; r < 24; r++) begin
      run_op(W'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
